qu_lsu_mem_port: RTL and testbench

//  Load/store adapter between the core's memory request handshake and one port of the Qu dual-port

---
 rtl/qu_lsu_mem_port_if.sv | 26 ++
 rtl/qu_lsu_mem_port.sv | 157 +++++++++++++++
 tb/tb_qu_lsu_mem_port.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/qu_lsu_mem_port_if.sv
// Core-side load/store request and response handshake for qu_lsu_mem_port.
// master = core issuing requests, slave = LSU memory port.
interface qu_lsu_mem_port_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/qu_lsu_mem_port.sv
// Load/store adapter onto one port of the Qu byte-write RAM: lane write enables, load extension.
// Optional macro QU_LSU_MISALIGN_ERR_EN turns misaligned/reserved-size accesses into error responses.
module qu_lsu_mem_port #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned RAM_DEPTH   = 1024,
    parameter int unsigned MEM_LATENCY = 2,
    localparam int unsigned AW         = $clog2(RAM_DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    qu_lsu_mem_port_if.slave core,
    output logic           mem_en,
    output logic [3:0]     mem_we,
    output logic [AW-1:0]  mem_addr,
    output logic [31:0]    mem_din,
    output logic           mem_regce,
    output logic           mem_rst,
    input  logic [31:0]    mem_dout,
    input  logic           mem_valid
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, ACK} state_t;

    state_t      state;
    logic        ready_q;
    logic        err_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  wait_cnt;

    logic        accept;
    logic        err;
    logic [1:0]  eff_size;
    logic [1:0]  eff_off;
    logic [3:0]  lane_mask;
    logic        lat_ok;
    logic        rd_hit;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_data;
    logic        unused_addr;

    assign accept         = core.req_valid & ready_q;
    assign core.req_ready = ready_q;
    assign unused_addr    = ^core.req_addr;

    always_comb begin
        eff_size = core.req_size;
        eff_off  = core.req_addr[1:0];
        err      = 1'b0;
`ifdef QU_LSU_MISALIGN_ERR_EN
        case (core.req_size)
            2'b01:   err = core.req_addr[0];
            2'b10:   err = |core.req_addr[1:0];
            2'b11:   err = 1'b1;
            default: err = 1'b0;
        endcase
`else
        if (core.req_size == 2'b11)
            eff_size = 2'b10;
`endif
        // Without the error check, offending low address bits snap to natural alignment.
        case (eff_size)
            2'b00:   eff_off = core.req_addr[1:0];
            2'b01:   eff_off = {core.req_addr[1], 1'b0};
            default: eff_off = 2'b00;
        endcase
    end

    always_comb begin
        case (eff_size)
            2'b00: begin
                lane_mask = 4'b0001 << eff_off;
                mem_din   = {4{core.req_wdata[7:0]}};
            end
            2'b01: begin
                lane_mask = 4'b0011 << eff_off;
                mem_din   = {2{core.req_wdata[15:0]}};
            end
            default: begin
                lane_mask = 4'hF;
                mem_din   = core.req_wdata;
            end
        endcase
        mem_we = (mem_en & core.req_we) ? lane_mask : 4'h0;
    end

    assign mem_en    = accept & ~err;
    assign mem_addr  = core.req_addr[AW+1:2];
    assign mem_regce = 1'b1;
    assign mem_rst   = rst;

    // Valid flags arriving before the nominal latency belong to a read cancelled by reset.
    assign lat_ok = (32'(wait_cnt) + 32'd1) >= MEM_LATENCY;
    assign rd_hit = (state == RD_WAIT) & mem_valid & lat_ok;

    always_comb begin
        case (off_q)
            2'd0:    lane_b = mem_dout[7:0];
            2'd1:    lane_b = mem_dout[15:8];
            2'd2:    lane_b = mem_dout[23:16];
            default: lane_b = mem_dout[31:24];
        endcase
        lane_h = off_q[1] ? mem_dout[31:16] : mem_dout[15:0];
        case (size_q)
            2'b00:   load_data = {{24{~uns_q & lane_b[7]}}, lane_b};
            2'b01:   load_data = {{16{~uns_q & lane_h[15]}}, lane_h};
            default: load_data = mem_dout;
        endcase
    end

    assign core.resp_valid = (state == ACK) | rd_hit;
    assign core.resp_err   = (state == ACK) & err_q;
    assign core.resp_rdata = rd_hit ? load_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ready_q  <= 1'b1;
            err_q    <= 1'b0;
            off_q    <= '0;
            size_q   <= '0;
            uns_q    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ready_q  <= 1'b0;
                        err_q    <= err;
                        off_q    <= eff_off;
                        size_q   <= eff_size;
                        uns_q    <= core.req_unsigned;
                        wait_cnt <= '0;
                        state    <= (core.req_we | err) ? ACK : RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (rd_hit) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end else if (wait_cnt != 2'b11) begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                ACK: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_qu_lsu_mem_port.sv
// Self-checking bench for qu_lsu_mem_port: vector table plus reset and back-to-back sequences,
// with a behavioural byte-write RAM of fixed read latency and an in-order response scoreboard.
module tb_qu_lsu_mem_port;
    localparam int unsigned LAT = 2;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_en;
        logic [3:0]  exp_we;
        logic [31:0] exp_din;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned due;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din;
    logic        mem_regce;
    logic        mem_rst;
    logic [31:0] mem_dout;
    logic        mem_valid;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;
    sb_t         sb[$];
    sb_t         e;
    vec_t        vecs[$];

    qu_lsu_mem_port_if #(.ADDR_WIDTH(32)) core ();

    qu_lsu_mem_port #(
        .ADDR_WIDTH (32),
        .RAM_DEPTH  (1024),
        .MEM_LATENCY(LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .core     (core.slave),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_regce(mem_regce),
        .mem_rst  (mem_rst),
        .mem_dout (mem_dout),
        .mem_valid(mem_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: two-stage read pipeline; mem_rst clears data only, so stale valids still arrive.
    logic [31:0] ram [1024];
    logic [31:0] rd1;
    logic        v1 = 1'b0;
    initial mem_valid = 1'b0;
    always @(posedge clk) begin
        v1 <= 1'b0;
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
            if (mem_we == 4'h0) begin
                rd1 <= ram[mem_addr];
                v1  <= 1'b1;
            end
        end
        mem_valid <= v1;
        mem_dout  <= mem_rst ? 32'h0 : rd1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (core.resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("resp_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("resp_rdata", core.resp_rdata, e.rdata);
                check("resp_err", {31'd0, core.resp_err}, {31'd0, e.err});
                check("resp_cycle", cyc, e.due);
            end
        end
    end

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic en, input logic [3:0] mwe, input logic [31:0] din,
                                input logic [31:0] rdata, input logic err);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_en = en; v.exp_we = mwe; v.exp_din = din; v.exp_rdata = rdata; v.exp_err = err;
        return v;
    endfunction

    task automatic issue(input vec_t v, input bit drop, input bit expect_resp,
                         output int unsigned acc_cyc);
        int unsigned n = 0;
        logic [31:0] a = v.addr;
        sb_t s;
        core.req_valid    = 1'b1;
        core.req_we       = v.we;
        core.req_size     = v.size;
        core.req_unsigned = v.uns;
        core.req_addr     = v.addr;
        core.req_wdata    = v.wdata;
        #1;
        while (core.req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        acc_cyc = cyc;
        if (core.req_ready !== 1'b1) begin
            check("accept_timeout", 32'd1, 32'd0);
            core.req_valid = 1'b0;
            return;
        end
        check("mem_en", {31'd0, mem_en}, {31'd0, v.exp_en});
        check("mem_we", {28'd0, mem_we}, {28'd0, v.exp_we});
        if (v.exp_en) check("mem_addr", {22'd0, mem_addr}, {22'd0, a[11:2]});
        if (v.exp_we != 4'h0) check("mem_din", mem_din, v.exp_din);
        if (expect_resp) begin
            s.rdata = v.exp_rdata;
            s.err   = v.exp_err;
            s.due   = acc_cyc + ((v.we || !v.exp_en) ? 1 : LAT);
            sb.push_back(s);
        end
        @(posedge clk); #1;
        check("ready_low_after_accept", {31'd0, core.req_ready}, 32'd0);
        if (drop) core.req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned t0, t1;
        core.req_valid = 1'b0; core.req_we = 1'b0; core.req_size = 2'b00;
        core.req_unsigned = 1'b0; core.req_addr = '0; core.req_wdata = '0;

        // we size uns addr wdata | en we din rdata err
        vecs.push_back(mk(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 1, 4'hF, 32'hDEADBEEF, 32'h0, 0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0,        1, 4'h0, 32'h0, 32'hDEADBEEF, 0));
        vecs.push_back(mk(1, 2'b00, 0, 32'h13, 32'h00000080, 1, 4'h8, 32'h80808080, 32'h0, 0));
        vecs.push_back(mk(0, 2'b00, 0, 32'h13, 32'h0,        1, 4'h0, 32'h0, 32'hFFFFFF80, 0));
        vecs.push_back(mk(0, 2'b00, 1, 32'h13, 32'h0,        1, 4'h0, 32'h0, 32'h00000080, 0));
        vecs.push_back(mk(1, 2'b10, 0, 32'h10, 32'h80011234, 1, 4'hF, 32'h80011234, 32'h0, 0));
        vecs.push_back(mk(0, 2'b01, 0, 32'h12, 32'h0,        1, 4'h0, 32'h0, 32'hFFFF8001, 0));
        vecs.push_back(mk(0, 2'b01, 0, 32'h10, 32'h0,        1, 4'h0, 32'h0, 32'h00001234, 0));
`ifdef QU_LSU_MISALIGN_ERR_EN
        vecs.push_back(mk(0, 2'b01, 0, 32'h11, 32'h0,        0, 4'h0, 32'h0, 32'h0, 1));
`else
        vecs.push_back(mk(0, 2'b01, 0, 32'h11, 32'h0,        1, 4'h0, 32'h0, 32'h00001234, 0));
`endif
        vecs.push_back(mk(1, 2'b01, 0, 32'h16, 32'h0000A5C3, 1, 4'hC, 32'hA5C3A5C3, 32'h0, 0));
        vecs.push_back(mk(0, 2'b01, 1, 32'h16, 32'h0,        1, 4'h0, 32'h0, 32'h0000A5C3, 0));
        vecs.push_back(mk(0, 2'b01, 0, 32'h16, 32'h0,        1, 4'h0, 32'h0, 32'hFFFFA5C3, 0));
        vecs.push_back(mk(1, 2'b00, 0, 32'h14, 32'h1234567F, 1, 4'h1, 32'h7F7F7F7F, 32'h0, 0));
        vecs.push_back(mk(0, 2'b00, 0, 32'h14, 32'h0,        1, 4'h0, 32'h0, 32'h0000007F, 0));
        vecs.push_back(mk(1, 2'b10, 0, 32'h10000020, 32'hCAFEF00D, 1, 4'hF, 32'hCAFEF00D, 32'h0, 0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h20, 32'h0,        1, 4'h0, 32'h0, 32'hCAFEF00D, 0));
        vecs.push_back(mk(1, 2'b10, 0, 32'h18, 32'h0,        1, 4'hF, 32'h0, 32'h0, 0));
`ifdef QU_LSU_MISALIGN_ERR_EN
        vecs.push_back(mk(0, 2'b11, 0, 32'h20, 32'h0,        0, 4'h0, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, 2'b10, 0, 32'h22, 32'h0,        0, 4'h0, 32'h0, 32'h0, 1));
        vecs.push_back(mk(1, 2'b01, 0, 32'h19, 32'h0000BEEF, 0, 4'h0, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, 2'b10, 1, 32'h18, 32'h0,        1, 4'h0, 32'h0, 32'h0, 0));
`else
        vecs.push_back(mk(0, 2'b11, 0, 32'h20, 32'h0,        1, 4'h0, 32'h0, 32'hCAFEF00D, 0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h22, 32'h0,        1, 4'h0, 32'h0, 32'hCAFEF00D, 0));
        vecs.push_back(mk(1, 2'b01, 0, 32'h19, 32'h0000BEEF, 1, 4'h3, 32'hBEEFBEEF, 32'h0, 0));
        vecs.push_back(mk(0, 2'b10, 1, 32'h18, 32'h0,        1, 4'h0, 32'h0, 32'h0000BEEF, 0));
`endif
        vecs.push_back(mk(1, 2'b00, 0, 32'h22, 32'h000000AB, 1, 4'h4, 32'hABABABAB, 32'h0, 0));
        vecs.push_back(mk(0, 2'b00, 1, 32'h22, 32'h0,        1, 4'h0, 32'h0, 32'h000000AB, 0));
        vecs.push_back(mk(0, 2'b01, 1, 32'h20, 32'h0,        1, 4'h0, 32'h0, 32'h0000F00D, 0));
        vecs.push_back(mk(0, 2'b01, 0, 32'h20, 32'h0,        1, 4'h0, 32'h0, 32'hFFFFF00D, 0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h20, 32'h0,        1, 4'h0, 32'h0, 32'hCAABF00D, 0));

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_resp_valid", {31'd0, core.resp_valid}, 32'd0);
        check("reset_resp_rdata", core.resp_rdata, 32'd0);
        check("reset_resp_err", {31'd0, core.resp_err}, 32'd0);
        check("reset_req_ready", {31'd0, core.req_ready}, 32'd1);

        foreach (vecs[i]) issue(vecs[i], 1'b1, 1'b1, t0);
        repeat (4) @(posedge clk);
        #1;

        // Reset one cycle after a load accept: the read must vanish without a response.
        issue(mk(0, 2'b10, 0, 32'h10, 32'h0, 1, 4'h0, 32'h0, 32'h0, 0), 1'b1, 1'b0, t0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_stale_valid_ignored", {31'd0, core.resp_valid}, 32'd0);
        check("rst_ready_after", {31'd0, core.req_ready}, 32'd1);
        repeat (6) @(posedge clk);
        #1;

        // Back-to-back with req_valid held high; accept spacing follows the FSM path length.
        issue(mk(1, 2'b10, 0, 32'h30, 32'h11223344, 1, 4'hF, 32'h11223344, 32'h0, 0), 1'b0, 1'b1, t0);
        issue(mk(0, 2'b10, 0, 32'h30, 32'h0, 1, 4'h0, 32'h0, 32'h11223344, 0), 1'b0, 1'b1, t1);
        check("b2b_gap_store", t1 - t0, 32'd2);
        t0 = t1;
        issue(mk(0, 2'b00, 1, 32'h31, 32'h0, 1, 4'h0, 32'h0, 32'h00000033, 0), 1'b0, 1'b1, t1);
        check("b2b_gap_load", t1 - t0, LAT + 1);
        t0 = t1;
        issue(mk(1, 2'b00, 0, 32'h30, 32'h000000EE, 1, 4'h1, 32'hEEEEEEEE, 32'h0, 0), 1'b0, 1'b1, t1);
        check("b2b_gap_load2", t1 - t0, LAT + 1);
        t0 = t1;
        issue(mk(0, 2'b10, 0, 32'h30, 32'h0, 1, 4'h0, 32'h0, 32'h112233EE, 0), 1'b1, 1'b1, t1);
        check("b2b_gap_store2", t1 - t0, 32'd2);

        repeat (6) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
